// File: rtl/rom_loader.sv
// Boot-time copier: pulls LOAD_SIZE bytes from the flash reader and writes them
// into the SRAM ROM area with a stretched write strobe, tracking a 16-bit sum.
module rom_loader #(
   parameter logic [16:0] LOAD_SIZE = 17'h1C000,
   parameter int unsigned WR_CYCLES = 4,
   parameter logic [19:0] TIMEOUT   = 20'hFFFFF
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        reload,
   input  logic        src_valid,
   input  logic [7:0]  src_data,
   output logic        src_ready,
   output logic [16:0] rom2ram_ram_address,
   output logic        rom2ram_ram_wren,
   output logic [7:0]  rom2ram_dataout,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] checksum
);

   // state  | meaning
   // IDLE   | clear address/checksum/timeout, start fetching next cycle
   // FETCH  | wait for a source byte, count idle cycles toward timeout
   // WRITE  | hold wren with stable address/data for WR_CYCLES cycles
   // GAP    | one cycle of deasserted wren, then advance or finish
   // DONE   | copy complete, outputs frozen until reload
   // ERROR  | source timed out, outputs frozen until reload
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WRITE, S_GAP, S_DONE, S_ERROR
   } state_t;

   localparam logic [3:0]  WR_LAST   = 4'(WR_CYCLES - 1);
   localparam logic [16:0] LAST_ADDR = LOAD_SIZE - 17'd1;
   localparam logic [19:0] TMO_LAST  = TIMEOUT - 20'd1;

   state_t      state_q;
   logic [16:0] addr_q;
   logic [7:0]  data_q;
   logic [15:0] csum_q;
   logic [19:0] tmo_q;
   logic [3:0]  wcnt_q;
   logic        wren_q;
   logic        busy_q;
   logic        done_q;
   logic        error_q;

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         csum_q  <= '0;
         tmo_q   <= '0;
         wcnt_q  <= '0;
         wren_q  <= 1'b0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               addr_q  <= '0;
               csum_q  <= '0;
               tmo_q   <= '0;
               state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (src_valid) begin
                  data_q  <= src_data;
                  csum_q  <= csum_q + {8'h00, src_data};
                  tmo_q   <= '0;
                  wcnt_q  <= WR_LAST;
                  wren_q  <= 1'b1;
                  state_q <= S_WRITE;
               end else if (tmo_q == TMO_LAST) begin
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
                  state_q <= S_ERROR;
               end else begin
                  tmo_q <= tmo_q + 20'd1;
               end
            end
            S_WRITE: begin
               if (wcnt_q == 4'd0) begin
                  wren_q  <= 1'b0;
                  state_q <= S_GAP;
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            S_GAP: begin
               // the last address is held in DONE rather than stepping past the area
               if (addr_q == LAST_ADDR) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  addr_q  <= addr_q + 17'd1;
                  state_q <= S_FETCH;
               end
            end
            S_DONE, S_ERROR: begin
               if (reload) begin
                  addr_q  <= '0;
                  csum_q  <= '0;
                  tmo_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign src_ready           = (state_q == S_FETCH) && src_valid;
   assign rom2ram_ram_address = addr_q;
   assign rom2ram_ram_wren    = wren_q;
   assign rom2ram_dataout     = data_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign error               = error_q;
   assign checksum            = csum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader with a timeline model of the copy sequence.
module tb_rom_loader;

   localparam int LOAD = 8;
   localparam int W    = 4;
   localparam int TMO  = 8;

   logic        clk28 = 1'b0;
   logic        rst_n = 1'b0;
   logic        reload = 1'b0;
   logic        src_valid = 1'b0;
   logic [7:0]  src_data = 8'h00;
   logic        src_ready;
   logic [16:0] address;
   logic        wren;
   logic [7:0]  dataout;
   logic        busy, done, error;
   logic [15:0] checksum;

   rom_loader #(
      .LOAD_SIZE(17'(LOAD)),
      .WR_CYCLES(W),
      .TIMEOUT  (20'(TMO))
   ) dut (
      .clk28              (clk28),
      .rst_n              (rst_n),
      .reload             (reload),
      .src_valid          (src_valid),
      .src_data           (src_data),
      .src_ready          (src_ready),
      .rom2ram_ram_address(address),
      .rom2ram_ram_wren   (wren),
      .rom2ram_dataout    (dataout),
      .busy               (busy),
      .done               (done),
      .error              (error),
      .checksum           (checksum)
   );

   always #5 clk28 = ~clk28;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: cycle index of the last accept fixes the write window and the
   // cycle when fetching resumes; end status 0=running 1=done 2=error.
   int t = 0;
   int m_fetch_from = 2;
   int m_acc = -100;
   int m_nbytes = 0;
   int m_sum = 0;
   int m_idle = 0;
   int m_end = 0;
   int m_data = 0;
   bit m_done_pending = 0;
   int exp_addr;
   bit fetching, writing;

   always @(negedge clk28) begin
      if (!rst_n) begin
         chk("rst_wren", wren, 0);
         chk("rst_ready", src_ready, 0);
         chk("rst_addr", address, 0);
         chk("rst_data", dataout, 0);
         chk("rst_csum", checksum, 0);
         chk("rst_done", done, 0);
         chk("rst_error", error, 0);
         chk("rst_busy", busy, 1);
         m_nbytes = 0; m_sum = 0; m_idle = 0; m_end = 0; m_data = 0;
         m_acc = -100; m_done_pending = 0; m_fetch_from = t + 2;
      end else begin
         if (m_end == 0 && m_done_pending && t >= m_fetch_from) m_end = 1;
         fetching = (m_end == 0) && (t >= m_fetch_from);
         writing  = (m_end == 0) && (m_nbytes > 0) && (t > m_acc) && (t <= m_acc + W);
         if (m_nbytes == 0)                      exp_addr = 0;
         else if (m_end == 1)                    exp_addr = LOAD - 1;
         else if (m_end == 2 || t >= m_fetch_from) exp_addr = m_nbytes;
         else                                    exp_addr = m_nbytes - 1;
         chk("wren", wren, 32'(writing));
         chk("src_ready", src_ready, 32'(fetching && src_valid));
         chk("address", address, 32'(exp_addr));
         chk("dataout", dataout, 32'(m_data));
         chk("checksum", checksum, 32'(m_sum));
         chk("busy", busy, 32'(m_end == 0));
         chk("done", done, 32'(m_end == 1));
         chk("error", error, 32'(m_end == 2));
         if (m_end != 0) begin
            if (reload) begin
               m_end = 0; m_nbytes = 0; m_sum = 0; m_idle = 0;
               m_acc = -100; m_done_pending = 0; m_fetch_from = t + 2;
            end
         end else if (fetching) begin
            if (src_valid) begin
               m_acc = t;
               m_nbytes++;
               m_sum = (m_sum + int'(src_data)) & 16'hFFFF;
               m_data = int'(src_data);
               m_idle = 0;
               m_fetch_from = t + W + 2;
               if (m_nbytes == LOAD) m_done_pending = 1;
            end else begin
               m_idle++;
               if (m_idle == TMO) m_end = 2;
            end
         end
      end
      t++;
   end

   int n, k, nacc, nwren, pct;
   bit saw4, hit;

   task automatic step(input bit v, input logic [7:0] d, input bit r);
      src_valid = v;
      src_data  = d;
      reload    = r;
      #1;
      if (src_valid && src_ready) nacc++;
      if (wren) nwren++;
      @(posedge clk28);
      #2;
   endtask

   task automatic full_copy(input string tag);
      nacc = 0; nwren = 0; n = 0; saw4 = 0;
      while (!done && n < 200) begin
         step(1'b1, 8'(17 * (nacc + 1)), 1'b0);
         n++;
         if (nacc == 4 && !saw4) begin
            saw4 = 1;
            chk({tag, "_csum4"}, checksum, 16'h00AA);
         end
      end
      chk({tag, "_latency"}, n, 49);
      chk({tag, "_csum"}, checksum, 16'h0264);
      chk({tag, "_nwren"}, nwren, 32);
      chk({tag, "_addr"}, address, 7);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_error"}, error, 0);
   endtask

   initial begin
      repeat (3) step(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      full_copy("copyA");

      // reload from DONE
      step(1'b0, 8'h00, 1'b1);
      chk("reload_busy", busy, 1);
      chk("reload_csum", checksum, 0);
      chk("reload_done", done, 0);

      // valid one cycle in three, stray reloads while busy
      nacc = 0; k = 0; n = 0;
      while (!(done || error) && n < 1000) begin
         step(k % 3 == 0, 8'($urandom), $urandom_range(7) == 0);
         k++; n++;
      end
      chk("third_done", done, 1);
      chk("third_nacc", nacc, LOAD);

      // timeout after two bytes
      step(1'b0, 8'h00, 1'b1);
      n = 1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, (i < 2) ? 8'h5A : 8'hC3, 1'b0);
         n++;
      end
      while (!error && n < 60) begin
         step(1'b0, 8'h00, 1'b0);
         n++;
      end
      chk("tmo_latency", n, 22);
      chk("tmo_addr", address, 2);
      chk("tmo_csum", checksum, 16'h011D);
      chk("tmo_wren", wren, 0);
      chk("tmo_done", done, 0);

      // random traffic with varying source rate
      for (int i = 0; i < 1500; i++) begin
         if (i % 150 == 0) pct = $urandom_range(95, 15);
         step($urandom_range(99) < pct, 8'($urandom),
              (done || error) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0));
      end

      // reset during the second wren cycle of byte 5
      n = 0;
      while (!(done || error) && n < 300) begin
         step(1'b1, 8'($urandom), 1'b0);
         n++;
      end
      chk("pre_rst_end", 32'(done || error), 1);
      step(1'b0, 8'h00, 1'b1);
      nacc = 0; n = 0; hit = 0;
      while (!hit && n < 100) begin
         step(1'b1, 8'(17 * (nacc + 1)), 1'b0);
         n++;
         hit = (address == 17'd4) && wren;
      end
      chk("rst_hit_byte5", 32'(hit), 1);
      step(1'b1, 8'h55, 1'b0);
      chk("rst_wren_before", wren, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_wren", wren, 0);
      chk("rst_async_addr", address, 0);
      chk("rst_async_busy", busy, 1);
      step(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      full_copy("copyB");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter LOAD_SIZE, default 17'h1C000, number of bytes copied (112 KB ROM area).
REQ-002 Parameter WR_CYCLES, default 4, clk28 cycles rom2ram_ram_wren is held per byte (legal 3..15).
REQ-003 Parameter TIMEOUT, default 20'hFFFFF, maximum clk28 cycles waited for one source byte.
REQ-004 clk28  in  1  sole clock, all state on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 reload  in  1  single-cycle request to repeat the copy; honoured only in DONE or ERROR.
REQ-007 src_valid  in  1  source (SPI flash reader) byte available.
REQ-008 src_data  in  8  source byte, valid when src_valid=1.
REQ-009 src_ready  out  1  one-cycle pulse; byte accepted.
REQ-010 rom2ram_ram_address  out  17  SRAM byte address inside the ROM area.
REQ-011 rom2ram_ram_wren  out  1  write strobe to the memory controller; has top priority there.
REQ-012 rom2ram_dataout  out  8  byte being written.
REQ-013 busy  out  1  copy in progress; holds the CPU in reset.
REQ-014 done  out  1  copy completed successfully.
REQ-015 error  out  1  copy aborted by source timeout.
REQ-016 checksum  out  16  modulo-2^16 sum of all bytes written since the copy started.

Function
REQ-017 States: IDLE, FETCH, WRITE, GAP, DONE, ERROR.
REQ-018 IDLE: entered at reset; goes to FETCH on the first clock after reset release, clearing address, checksum and timeout counter.
REQ-019 FETCH: src_ready is 1 in the same cycle src_valid=1 (combinational accept); src_data latches into rom2ram_dataout, checksum += src_data, then to WRITE.
REQ-020 FETCH: timeout counter increments each cycle without src_valid and is cleared on accept; reaching TIMEOUT -> ERROR.
REQ-021 WRITE: rom2ram_ram_wren=1 for exactly WR_CYCLES cycles with address and data stable, then to GAP.
REQ-022 GAP: wren=0 for exactly 1 cycle (the memory controller needs a deasserted strobe to start the next write cycle), address then increments.
REQ-023 After GAP: if the byte just written was at address LOAD_SIZE-1 -> DONE, else -> FETCH.
REQ-024 Address stays within 17 bits; LOAD_SIZE-1 is the last address written; no wrap.
REQ-025 busy=1 in IDLE, FETCH, WRITE and GAP; done=1 only in DONE; error=1 only in ERROR; done and error are never 1 together.
REQ-026 DONE/ERROR: outputs hold, wren=0, src_ready=0; reload=1 -> IDLE behaviour (clear, then FETCH next cycle).
REQ-027 reload while busy=1 is ignored.
REQ-028 checksum holds its final value in DONE and its partial value in ERROR until the next reload.
REQ-029 src_ready is never 1 outside FETCH; src_valid outside FETCH is not consumed.

Reset
REQ-030 rst_n=0 forces IDLE at once: wren=0, src_ready=0, address=0, dataout=0, checksum=0, done=0, error=0, busy=1.
REQ-031 Reset asserted mid-write drops wren immediately; the copy restarts from address 0 after release.

Verification
REQ-032 LOAD_SIZE=4, source 8'h11,22,33,44 always valid -> four 4-cycle wren pulses at addresses 0..3 separated by 1-cycle gaps; done=1, checksum=16'h00AA, busy=0.
REQ-033 Source valid 1 cycle in 3 -> every byte is accepted exactly once, src_ready pulses only on valid cycles, address is never skipped or repeated.
REQ-034 TIMEOUT=8, source silent after 2 bytes -> error=1 after the 8th idle cycle, address=2, checksum equals the sum of those 2 bytes, wren=0.
REQ-035 reload in DONE -> next cycle busy=1 and checksum=0, full copy repeats; reload while busy -> no effect.
REQ-036 rst_n pulsed low during the 2nd wren cycle of byte 5 -> wren drops asynchronously; after release the copy restarts at address 0.
REQ-037 Full LOAD_SIZE=17'h1C000 run -> last write at 17'h1BFFF, no write at 17'h1C000, done asserted.
